instruction_decode_buffer: RTL and testbench
============================================

Name: instruction_decode_buffer

Overview:
Parametrised decode stage between fetch and register read. It buffers fetched instructions with their PCs in a DEPTH-entry FIFO and decodes the head entry. Decoded fields go into a registered output stage with valid/ready handshakes. Adds flush, RV32E/M legality checking, illegal-instruction flagging and occupancy reporting.

Parameters:
XLEN, 32, width of PC
DEPTH, 4, FIFO entries (power of two, >=2)
ENABLE_E, 0, 1 = RV32E: any enabled register index >=16 is illegal
ENABLE_M, 1, 0 = OP with funct7==0000001 is illegal

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  discard FIFO and output stage
in_valid  in  1  fetch offers instruction
in_ready  out  1  buffer accepts (= FIFO not full)
in_instruction  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  consumer accepts bundle
out_pc  out  XLEN  PC of bundle
out_instruction  out  32  raw instruction
out_instruction_type  out  3  R/I/S/B/U/J/INVALID encoding
out_opcode / out_funct3 / out_funct7 / out_funct12  out  7/3/7/12  fields
out_read_index_1 / out_read_index_2 / out_write_index  out  5 each  register indices
out_csr_index  out  12  instr[31:20]
out_read_enable_1 / out_read_enable_2 / out_write_enable  out  1 each  register port enables
out_csr_read_enable / out_csr_write_enable  out  1 each  CSR enables
out_illegal  out  1  bundle is an illegal instruction
occupancy  out  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset (async, active-high): FIFO empty, occupancy=0, in_ready=1, out_valid=0, out_illegal=0, all out_* fields and enables 0.
- Push: in_valid & in_ready at an edge writes {instruction, pc} at the tail. There is no push when full and no same-cycle pass-through.
- Output load: the stage is free when !out_valid | out_ready. At an edge where the stage is free and the FIFO is non-empty, it pops the head and registers its decode. Otherwise, when free, out_valid goes to 0.
- Latency: an instruction pushed at edge N is out_valid after edge N+1 at the earliest. Sustained throughput is 1/cycle with out_ready=1.
- Push and pop in the same edge leave occupancy unchanged, and pointers wrap modulo DEPTH.
- Bundle stability: while out_valid & !out_ready, all out_* hold steady.
- Flush: at the edge where flush=1, the FIFO empties, out_valid=0 and any push that cycle is dropped. Flush takes priority over push and pop.
- Decode type: opcode class OP/OP_FP→R, LOAD/LOAD_FP/OP_IMM/OP_IMM_32/JALR/SYSTEM→I, STORE/STORE_FP→S, BRANCH→B, AUIPC/LUI→U, JAL→J, otherwise INVALID.
- Read enable 1: R/I/S/B. Read enable 2: R/S/B.
- Write enable: R/I/U/J, forced 0 when rd==0.
- CSR read enable: SYSTEM with funct3 in {CSRRW,CSRRS,CSRRC,CSRRWI,CSRRSI,CSRRCI}.
- CSR write enable: same condition, additionally gated by !(csr[11]&csr[10]), i.e. read-only CSRs are not written.
- Illegal if any of:
  - type INVALID;
  - instr[1:0]!=2'b11;
  - SYSTEM with funct3==3'b100;
  - ENABLE_M==0 and OP with funct7==0000001;
  - ENABLE_E==1 and any enabled index (rs1, rs2 or rd) has bit 4 set.
- Illegal bundles are still delivered, with out_illegal=1 and every read, write and CSR enable forced to 0.
- Reset mid-operation clears everything immediately; there is no partial bundle.

Decomposition:
- Shared defines file: opcode constants, instruction-type encodings, CSR funct3 codes, ENABLE/DISABLE.
- Sub-module: instruction_field_decoder, purely combinational. It maps a 32-bit instruction plus ENABLE_E/ENABLE_M to the full decoded bundle including illegal. It is instantiated once, on the FIFO head.
- The FIFO is kept inline: pointers, count and a storage array.

Test Plan:
- Single push of 0x003100B3 (add x1,x2,x3), pc=0x100, out_ready=1 → out_valid 2 edges after the push; type R, rs1=2, rs2=3, rd=1; re1=re2=we=1; illegal=0; out_pc=0x100.
- Push 0xC00092F3 (csrrw x5,0xC00,x1) → csr_index=0xC00, csr_read_enable=1, csr_write_enable=0, write_enable=1.
- ENABLE_E=1, push 0x00310893 (addi x17,x2,3) → out_illegal=1, all enables 0. With ENABLE_E=0 the same word is legal with we=1.
- Hold out_ready=0, push DEPTH+2 instructions back-to-back → in_ready drops after DEPTH+1 accepted (DEPTH in the FIFO plus 1 in the output stage). The output bundle is stable. Release out_ready → entries emerge in order, 1 per cycle.
- Fill 3 entries, assert flush with in_valid=1 → next cycle occupancy=0, out_valid=0, the flush-cycle instruction never appears.
- Assert reset asynchronously mid-stream, between edges → out_valid and occupancy go to 0 without waiting for a clock edge. After release, a new push decodes correctly.

Source files
------------

// File: rtl/instruction_decode_buffer_pkg.sv
// ============================================================================
// Module  : instruction_decode_buffer_pkg
// Brief   : RV32 opcode classes, instruction-type codes and decoded bundle type
// Revision: 1.0
// ============================================================================
`default_nettype none

package instruction_decode_buffer_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;
   localparam logic [2:0] F3_SYS_RSVD = 3'b100;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // INVALID is zero so a reset output stage reads as "no instruction".
   typedef enum logic [2:0] {
      TYPE_INVALID = 3'd0,
      TYPE_R       = 3'd1,
      TYPE_I       = 3'd2,
      TYPE_S       = 3'd3,
      TYPE_B       = 3'd4,
      TYPE_U       = 3'd5,
      TYPE_J       = 3'd6
   } instr_type_e;

   typedef struct packed {
      instr_type_e instruction_type;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] funct12;
      logic [4:0]  read_index_1;
      logic [4:0]  read_index_2;
      logic [4:0]  write_index;
      logic [11:0] csr_index;
      logic        read_enable_1;
      logic        read_enable_2;
      logic        write_enable;
      logic        csr_read_enable;
      logic        csr_write_enable;
      logic        illegal;
   } decode_t;

   function automatic logic is_csr_funct3(input logic [2:0] f3);
      return (f3 == F3_CSRRW)  || (f3 == F3_CSRRS)  || (f3 == F3_CSRRC) ||
             (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decode_buffer_field_decoder.sv
// ============================================================================
// Module  : instruction_field_decoder
// Brief   : Combinational RV32 field decode with E/M legality checking
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_field_decoder
   import instruction_decode_buffer_pkg::*;
#(
   parameter int unsigned ENABLE_E = 0,
   parameter int unsigned ENABLE_M = 1
) (
   input  logic [31:0] instruction,
   output decode_t     decoded
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;
   instr_type_e w_type;
   logic        w_re1;
   logic        w_re2;
   logic        w_we;
   logic        w_csr_re;
   logic        w_csr_we;
   logic        w_illegal;

   assign w_opc = instruction[6:0];
   assign w_f3  = instruction[14:12];
   assign w_f7  = instruction[31:25];
   assign w_rs1 = instruction[19:15];
   assign w_rs2 = instruction[24:20];
   assign w_rd  = instruction[11:7];

   always_comb begin
      w_type = TYPE_INVALID;
      case (w_opc)
         OPC_OP, OPC_OP_FP:                        w_type = TYPE_R;
         OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM,
         OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM:      w_type = TYPE_I;
         OPC_STORE, OPC_STORE_FP:                  w_type = TYPE_S;
         OPC_BRANCH:                               w_type = TYPE_B;
         OPC_AUIPC, OPC_LUI:                       w_type = TYPE_U;
         OPC_JAL:                                  w_type = TYPE_J;
         default:                                  w_type = TYPE_INVALID;
      endcase
   end

   always_comb begin
      w_re1 = (w_type == TYPE_R) || (w_type == TYPE_I) ||
              (w_type == TYPE_S) || (w_type == TYPE_B);
      w_re2 = (w_type == TYPE_R) || (w_type == TYPE_S) || (w_type == TYPE_B);
      w_we  = ((w_type == TYPE_R) || (w_type == TYPE_I) ||
               (w_type == TYPE_U) || (w_type == TYPE_J)) && (w_rd != 5'd0);
      w_csr_re = (w_opc == OPC_SYSTEM) && is_csr_funct3(w_f3);
      // CSR addresses with [11:10]==2'b11 are read-only
      w_csr_we = w_csr_re && !(instruction[31] && instruction[30]);

      w_illegal = (w_type == TYPE_INVALID) ||
                  (instruction[1:0] != 2'b11) ||
                  ((w_opc == OPC_SYSTEM) && (w_f3 == F3_SYS_RSVD));
      if (ENABLE_M == 0 && w_opc == OPC_OP && w_f7 == F7_MULDIV)
         w_illegal = 1'b1;
      if (ENABLE_E == 1 && ((w_re1 && w_rs1[4]) || (w_re2 && w_rs2[4]) ||
                            (w_we && w_rd[4])))
         w_illegal = 1'b1;
   end

   always_comb begin
      decoded                  = '0;
      decoded.instruction_type = w_type;
      decoded.opcode           = w_opc;
      decoded.funct3           = w_f3;
      decoded.funct7           = w_f7;
      decoded.funct12          = instruction[31:20];
      decoded.read_index_1     = w_rs1;
      decoded.read_index_2     = w_rs2;
      decoded.write_index      = w_rd;
      decoded.csr_index        = instruction[31:20];
      decoded.illegal          = w_illegal;
      decoded.read_enable_1    = w_re1 && !w_illegal;
      decoded.read_enable_2    = w_re2 && !w_illegal;
      decoded.write_enable     = w_we && !w_illegal;
      decoded.csr_read_enable  = w_csr_re && !w_illegal;
      decoded.csr_write_enable = w_csr_we && !w_illegal;
   end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_buffer.sv
// ============================================================================
// Module  : instruction_decode_buffer
// Brief   : Fetch-to-register-read FIFO with registered decode output stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_decode_buffer
   import instruction_decode_buffer_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ENABLE_E = 0,
   parameter int unsigned ENABLE_M = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instruction,
   input  logic [XLEN-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [31:0]                out_instruction,
   output logic [2:0]                 out_instruction_type,
   output logic [6:0]                 out_opcode,
   output logic [2:0]                 out_funct3,
   output logic [6:0]                 out_funct7,
   output logic [11:0]                out_funct12,
   output logic [4:0]                 out_read_index_1,
   output logic [4:0]                 out_read_index_2,
   output logic [4:0]                 out_write_index,
   output logic [11:0]                out_csr_index,
   output logic                       out_read_enable_1,
   output logic                       out_read_enable_2,
   output logic                       out_write_enable,
   output logic                       out_csr_read_enable,
   output logic                       out_csr_write_enable,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH+1);
   localparam int unsigned ENTRY_W = 32 + XLEN;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               out_valid_q, out_valid_d;
   logic [XLEN-1:0]    out_pc_q, out_pc_d;
   logic [31:0]        out_instr_q, out_instr_d;
   decode_t            out_dec_q, out_dec_d;

   logic               w_push;
   logic               w_pop;
   logic               w_stage_free;
   logic               w_not_empty;
   logic [ENTRY_W-1:0] w_head;
   decode_t            w_head_dec;

   assign w_head       = mem_q[rd_ptr_q];
   assign w_not_empty  = (count_q != '0);
   assign w_stage_free = !out_valid_q || out_ready;
   assign in_ready     = (count_q != CNT_W'(DEPTH));
   assign w_push       = in_valid && in_ready && !flush;
   assign w_pop        = w_stage_free && w_not_empty && !flush;

   instruction_field_decoder #(
      .ENABLE_E (ENABLE_E),
      .ENABLE_M (ENABLE_M)
   ) u_field_decoder (
      .instruction (w_head[ENTRY_W-1:XLEN]),
      .decoded     (w_head_dec)
   );

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = {in_instruction, in_pc};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      out_dec_d   = out_dec_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (w_pop) begin
         out_valid_d = 1'b1;
         out_pc_d    = w_head[XLEN-1:0];
         out_instr_d = w_head[ENTRY_W-1:XLEN];
         out_dec_d   = w_head_dec;
      end else if (w_stage_free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++)
            mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= '0;
         out_dec_q   <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_dec_q   <= out_dec_d;
      end
   end

   assign occupancy            = count_q;
   assign out_valid            = out_valid_q;
   assign out_pc               = out_pc_q;
   assign out_instruction      = out_instr_q;
   assign out_instruction_type = out_dec_q.instruction_type;
   assign out_opcode           = out_dec_q.opcode;
   assign out_funct3           = out_dec_q.funct3;
   assign out_funct7           = out_dec_q.funct7;
   assign out_funct12          = out_dec_q.funct12;
   assign out_read_index_1     = out_dec_q.read_index_1;
   assign out_read_index_2     = out_dec_q.read_index_2;
   assign out_write_index      = out_dec_q.write_index;
   assign out_csr_index        = out_dec_q.csr_index;
   assign out_read_enable_1    = out_dec_q.read_enable_1;
   assign out_read_enable_2    = out_dec_q.read_enable_2;
   assign out_write_enable     = out_dec_q.write_enable;
   assign out_csr_read_enable  = out_dec_q.csr_read_enable;
   assign out_csr_write_enable = out_dec_q.csr_write_enable;
   assign out_illegal          = out_dec_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode_buffer.sv
// ============================================================================
// Module  : tb_instruction_decode_buffer
// Brief   : Directed bench for instruction_decode_buffer (RV32I and RV32E copies)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_decode_buffer;
   import instruction_decode_buffer_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, out_ready;
   logic [31:0]     in_instruction;
   logic [XLEN-1:0] in_pc;

   logic            in_ready, out_valid;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instruction;
   logic [2:0]      out_type;
   logic [6:0]      out_opcode, out_funct7;
   logic [2:0]      out_funct3;
   logic [11:0]     out_funct12, out_csr_index;
   logic [4:0]      out_rs1, out_rs2, out_rd;
   logic            out_re1, out_re2, out_we, out_csr_re, out_csr_we, out_illegal;
   logic [CW-1:0]   occupancy;

   logic            e_in_ready, e_out_valid;
   logic [XLEN-1:0] e_out_pc;
   logic [31:0]     e_out_instruction;
   logic [2:0]      e_out_type;
   logic [6:0]      e_out_opcode, e_out_funct7;
   logic [2:0]      e_out_funct3;
   logic [11:0]     e_out_funct12, e_out_csr_index;
   logic [4:0]      e_out_rs1, e_out_rs2, e_out_rd;
   logic            e_out_re1, e_out_re2, e_out_we, e_out_csr_re, e_out_csr_we, e_out_illegal;
   logic [CW-1:0]   e_occupancy;

   int checks   = 0;
   int failures = 0;
   int accepted;

   always #5 clk = ~clk;

   instruction_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_E(0), .ENABLE_M(1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instruction(out_instruction),
      .out_instruction_type(out_type), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_funct12(out_funct12),
      .out_read_index_1(out_rs1), .out_read_index_2(out_rs2), .out_write_index(out_rd),
      .out_csr_index(out_csr_index),
      .out_read_enable_1(out_re1), .out_read_enable_2(out_re2), .out_write_enable(out_we),
      .out_csr_read_enable(out_csr_re), .out_csr_write_enable(out_csr_we),
      .out_illegal(out_illegal), .occupancy(occupancy)
   );

   instruction_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_E(1), .ENABLE_M(1)) dut_e (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(e_in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(e_out_valid), .out_ready(out_ready),
      .out_pc(e_out_pc), .out_instruction(e_out_instruction),
      .out_instruction_type(e_out_type), .out_opcode(e_out_opcode),
      .out_funct3(e_out_funct3), .out_funct7(e_out_funct7), .out_funct12(e_out_funct12),
      .out_read_index_1(e_out_rs1), .out_read_index_2(e_out_rs2), .out_write_index(e_out_rd),
      .out_csr_index(e_out_csr_index),
      .out_read_enable_1(e_out_re1), .out_read_enable_2(e_out_re2), .out_write_enable(e_out_we),
      .out_csr_read_enable(e_out_csr_re), .out_csr_write_enable(e_out_csr_we),
      .out_illegal(e_out_illegal), .occupancy(e_occupancy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one word with out_ready=1; returns with its bundle on the output.
   task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc);
      out_ready      = 1'b1;
      in_valid       = 1'b1;
      in_instruction = instr;
      in_pc          = pc;
      tick();
      in_valid = 1'b0;
      chk("latency_not_early", {31'd0, out_valid}, 32'd0);
      tick();
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instruction = '0; in_pc = '0;
      #2 reset = 1'b1;
      #10;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_enables", {27'd0, out_re1, out_re2, out_we, out_csr_re, out_csr_we}, 32'd0);
      @(negedge clk) reset = 1'b0;

      // add x1, x2, x3
      send(32'h003100B3, 32'h100);
      chk("add_type", {29'd0, out_type}, {29'd0, TYPE_R});
      chk("add_rs1", {27'd0, out_rs1}, 32'd2);
      chk("add_rs2", {27'd0, out_rs2}, 32'd3);
      chk("add_rd", {27'd0, out_rd}, 32'd1);
      chk("add_en", {29'd0, out_re1, out_re2, out_we}, 32'h7);
      chk("add_illegal", {31'd0, out_illegal}, 32'd0);
      chk("add_pc", out_pc, 32'h100);
      chk("add_instr", out_instruction, 32'h003100B3);
      chk("add_occ", {29'd0, occupancy}, 32'd0);
      chk("add_e_legal", {31'd0, e_out_illegal}, 32'd0);
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // csrrw x5, 0xC00, x1 : read-only CSR
      send(32'hC00092F3, 32'h104);
      chk("csrro_index", {20'd0, out_csr_index}, 32'hC00);
      chk("csrro_re", {31'd0, out_csr_re}, 32'd1);
      chk("csrro_we", {31'd0, out_csr_we}, 32'd0);
      chk("csrro_wen", {31'd0, out_we}, 32'd1);
      chk("csrro_type", {29'd0, out_type}, {29'd0, TYPE_I});
      tick();

      // csrrw x5, 0x300, x1 : writable CSR
      send(32'h300092F3, 32'h108);
      chk("csrrw_we", {30'd0, out_csr_re, out_csr_we}, 32'h3);
      tick();

      // addi x17, x2, 3 : legal on RV32I, illegal on RV32E
      send(32'h00310893, 32'h10C);
      chk("addi17_i_legal", {31'd0, out_illegal}, 32'd0);
      chk("addi17_i_we", {31'd0, out_we}, 32'd1);
      chk("addi17_i_rd", {27'd0, out_rd}, 32'd17);
      chk("addi17_e_illegal", {31'd0, e_out_illegal}, 32'd1);
      chk("addi17_e_en", {27'd0, e_out_re1, e_out_re2, e_out_we, e_out_csr_re, e_out_csr_we}, 32'd0);
      chk("addi17_e_valid", {31'd0, e_out_valid}, 32'd1);
      tick();

      // addi x0, x0, 0 : rd==0 suppresses the write
      send(32'h00000013, 32'h110);
      chk("nop_we", {31'd0, out_we}, 32'd0);
      chk("nop_re1", {31'd0, out_re1}, 32'd1);
      chk("nop_illegal", {31'd0, out_illegal}, 32'd0);
      tick();

      // all-zero word: invalid opcode, low bits not 11
      send(32'h00000000, 32'h114);
      chk("zero_illegal", {31'd0, out_illegal}, 32'd1);
      chk("zero_type", {29'd0, out_type}, {29'd0, TYPE_INVALID});
      tick();

      // SYSTEM funct3=100 is reserved
      send(32'h00004073, 32'h118);
      chk("sys100_illegal", {31'd0, out_illegal}, 32'd1);
      chk("sys100_en", {27'd0, out_re1, out_re2, out_we, out_csr_re, out_csr_we}, 32'd0);
      tick();

      // Back-pressure: DEPTH in FIFO plus one in the output stage
      out_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         in_valid       = 1'b1;
         in_instruction = 32'h00000093 | (i << 20);
         in_pc          = 32'h200 + 4 * i;
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      chk("full_accepted", accepted, DEPTH + 1);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_occ", {29'd0, occupancy}, DEPTH);
      chk("full_head_pc", out_pc, 32'h200);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", out_pc, 32'h200);
         chk("stall_instr", out_instruction, 32'h00000093);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      for (int i = 0; i < int'(DEPTH) + 1; i++) begin
         chk("order_valid", {31'd0, out_valid}, 32'd1);
         chk("order_pc", out_pc, 32'h200 + 4 * i);
         chk("order_imm", {20'd0, out_funct12}, i);
         tick();
      end
      chk("order_drained", {31'd0, out_valid}, 32'd0);
      chk("order_occ", {29'd0, occupancy}, 32'd0);

      // Flush with a concurrent push
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid       = 1'b1;
         in_instruction = 32'h003100B3;
         in_pc          = 32'h300 + 4 * i;
         tick();
      end
      chk("preflush_occ", {29'd0, occupancy}, 32'd3);
      chk("preflush_valid", {31'd0, out_valid}, 32'd1);
      flush          = 1'b1;
      in_valid       = 1'b1;
      in_pc          = 32'h3F0;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", {29'd0, occupancy}, 32'd0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_dropped", {31'd0, out_valid}, 32'd0);
      end

      // Asynchronous reset between edges
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid       = 1'b1;
         in_instruction = 32'h00310893;
         in_pc          = 32'h400 + 4 * i;
         tick();
      end
      in_valid = 1'b0;
      chk("prerst_valid", {31'd0, out_valid}, 32'd1);
      chk("prerst_occ", {29'd0, occupancy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_occ", {29'd0, occupancy}, 32'd0);
      chk("arst_pc", out_pc, 32'd0);
      chk("arst_we", {31'd0, out_we}, 32'd0);
      #1 reset = 1'b0;

      send(32'h003100B3, 32'h500);
      chk("post_rst_pc", out_pc, 32'h500);
      chk("post_rst_type", {29'd0, out_type}, {29'd0, TYPE_R});
      chk("post_rst_rd", {27'd0, out_rd}, 32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
